// File: rtl/astro_pkg.sv
// Shared definitions for the move path: opcodes, LED/memory field positions
// and the playback FSM state encoding.
package astro_pkg;

  localparam logic [1:0] OP_CIMA  = 2'b00;
  localparam logic [1:0] OP_BAIXO = 2'b01;
  localparam logic [1:0] OP_ESQ   = 2'b10;
  localparam logic [1:0] OP_DIR   = 2'b11;

  localparam int BIT_TIRO     = 0;
  localparam int BIT_ESPECIAL = 1;
  localparam int DIR_LSB      = 2;

  localparam int MEM_OP_LSB   = 0;
  localparam int MEM_OP_MSB   = 1;
  localparam int MEM_TIRO     = 2;
  localparam int MEM_ESPECIAL = 3;

  localparam int WORD_W = 4;
  localparam int LED_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    LE,
    CARREGA,
    ACESO,
    APAGADO,
    FIM
  } estado_t;

endpackage

// File: rtl/codifica_jogada.sv
// Combinational encoder: stored 4-bit move word to the 6-bit LED layout used
// by the switches (one-hot direction on the upper bits).
module codifica_jogada
  import astro_pkg::*;
(
  input  logic [WORD_W-1:0] palavra_i,
  output logic [LED_W-1:0]  leds_o
);

  always_comb begin
    leds_o               = '0;
    leds_o[BIT_TIRO]     = palavra_i[MEM_TIRO];
    leds_o[BIT_ESPECIAL] = palavra_i[MEM_ESPECIAL];
    case (palavra_i[MEM_OP_MSB:MEM_OP_LSB])
      OP_CIMA:  leds_o[DIR_LSB + 0] = 1'b1;
      OP_BAIXO: leds_o[DIR_LSB + 1] = 1'b1;
      OP_ESQ:   leds_o[DIR_LSB + 2] = 1'b1;
      OP_DIR:   leds_o[DIR_LSB + 3] = 1'b1;
      default:  leds_o[DIR_LSB + 0] = 1'b1;
    endcase
  end

endmodule

// File: rtl/exibe_jogada.sv
// Sequence playback: walks memory from address 0 to the latched limit, lighting
// each move for T_ACESO cycles followed by T_APAGADO blank cycles.
module exibe_jogada
  import astro_pkg::*;
#(
  parameter int AW        = 4,
  parameter int T_ACESO   = 50_000_000,
  parameter int T_APAGADO = 25_000_000,
  parameter int CW        = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic [AW-1:0]     limite,
  input  logic [WORD_W-1:0] dado_memoria,
  output logic [AW-1:0]     endereco,
  output logic [LED_W-1:0]  leds,
  output logic              ocupado,
  output logic              fim
);

  localparam logic [CW-1:0] ULTIMO_ACESO   = CW'(T_ACESO - 1);
  localparam logic [CW-1:0] ULTIMO_APAGADO = CW'(T_APAGADO - 1);

  estado_t           estado_q, estado_d;
  logic [AW-1:0]     endereco_q, endereco_d;
  logic [AW-1:0]     limite_q, limite_d;
  logic [WORD_W-1:0] palavra_q, palavra_d;
  logic [CW-1:0]     contador_q, contador_d;
  logic [LED_W-1:0]  ledsCodificados;

  codifica_jogada u_codifica (
    .palavra_i (palavra_q),
    .leds_o    (ledsCodificados)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= IDLE;
      endereco_q <= '0;
      limite_q   <= '0;
      palavra_q  <= '0;
      contador_q <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      palavra_q  <= palavra_d;
      contador_q <= contador_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    palavra_d  = palavra_q;
    contador_d = contador_q;
    case (estado_q)
      IDLE: begin
        if (iniciar) begin
          endereco_d = '0;
          limite_d   = limite;
          estado_d   = LE;
        end
      end
      LE: estado_d = CARREGA;
      CARREGA: begin
        palavra_d  = dado_memoria;
        contador_d = '0;
        estado_d   = ACESO;
      end
      ACESO: begin
        if (contador_q == ULTIMO_ACESO) begin
          contador_d = '0;
          estado_d   = APAGADO;
        end else begin
          contador_d = contador_q + CW'(1);
        end
      end
      APAGADO: begin
        if (contador_q == ULTIMO_APAGADO) begin
          contador_d = '0;
          if (endereco_q == limite_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + AW'(1);
            estado_d   = LE;
          end
        end else begin
          contador_d = contador_q + CW'(1);
        end
      end
      FIM: estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
    // Abort overrides whatever the state logic decided above.
    if (parar) begin
      estado_d   = IDLE;
      endereco_d = '0;
    end
  end

  assign endereco = endereco_q;
  assign leds     = (estado_q == ACESO) ? ledsCodificados : '0;
  assign ocupado  = (estado_q != IDLE);
  assign fim      = (estado_q == FIM);

endmodule

// File: tb/tb_exibe_jogada.sv
// Self-checking bench for exibe_jogada: random memory contents and limits,
// expected LED/address/fim traces built from the playback rules.
module tb_exibe_jogada;

  localparam int AW = 4;
  localparam int TA = 4;
  localparam int TP = 2;
  localparam int CW = 26;

  logic          clock;
  logic          reset;
  logic          iniciar;
  logic          parar;
  logic [AW-1:0] limite;
  logic [3:0]    dadoMemoria;
  logic [AW-1:0] endereco;
  logic [5:0]    leds;
  logic          ocupado;
  logic          fim;
  logic [3:0]    palavraSweep;
  logic [5:0]    ledsSweep;

  logic [3:0] mem [16];
  int vectors;
  int miscompares;

  exibe_jogada #(
    .AW        (AW),
    .T_ACESO   (TA),
    .T_APAGADO (TP),
    .CW        (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .parar        (parar),
    .limite       (limite),
    .dado_memoria (dadoMemoria),
    .endereco     (endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .fim          (fim)
  );

  codifica_jogada u_enc (
    .palavra_i (palavraSweep),
    .leds_o    (ledsSweep)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory: data valid one cycle after the address.
  always @(posedge clock) dadoMemoria <= mem[endereco];

  function automatic logic [5:0] modelLeds(input logic [3:0] w);
    logic [5:0] r;
    r    = 6'(1 << (2 + int'(w[1:0])));
    r[0] = w[2];
    r[1] = w[3];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fillMemory();
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  // Starts a playback from IDLE (caller sits at a negedge) and checks every cycle.
  task automatic runPlayback(input int lim, input int disturbAt, input bit iniciarNoFim);
    logic [5:0]    eLeds[$];
    logic [AW-1:0] eAddr[$];
    bit            eFim[$];
    for (int m = 0; m <= lim; m++) begin
      for (int k = 0; k < 2 + TA + TP; k++) begin
        eLeds.push_back((k >= 2 && k < 2 + TA) ? modelLeds(mem[m]) : 6'd0);
        eAddr.push_back(AW'(m));
        eFim.push_back(1'b0);
      end
    end
    eLeds.push_back(6'd0);
    eAddr.push_back(AW'(lim));
    eFim.push_back(1'b1);
    limite  = AW'(lim);
    iniciar = 1'b1;
    for (int n = 0; n < eLeds.size(); n++) begin
      @(negedge clock);
      checkOutput($sformatf("leds lim%0d c%0d", lim, n + 1), 32'(leds), 32'(eLeds[n]));
      checkOutput($sformatf("addr lim%0d c%0d", lim, n + 1), 32'(endereco), 32'(eAddr[n]));
      checkOutput($sformatf("fim lim%0d c%0d", lim, n + 1), 32'(fim), 32'(eFim[n]));
      checkOutput($sformatf("ocup lim%0d c%0d", lim, n + 1), 32'(ocupado), 32'd1);
      iniciar = 1'b0;
      if (disturbAt != 0 && n + 1 == disturbAt) begin
        iniciar = 1'b1;
        limite  = '0;
      end
      if (iniciarNoFim && n == eLeds.size() - 1) iniciar = 1'b1;
    end
    @(negedge clock);
    checkOutput("ocup after fim", 32'(ocupado), 32'd0);
    checkOutput("fim after fim", 32'(fim), 32'd0);
    iniciar = 1'b0;
    @(negedge clock);
    checkOutput("ocup idle", 32'(ocupado), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset        = 1'b1;
    iniciar      = 1'b0;
    parar        = 1'b0;
    limite       = '0;
    palavraSweep = '0;
    fillMemory();
    repeat (2) @(negedge clock);
    checkOutput("rst leds", 32'(leds), 32'd0);
    checkOutput("rst ocup", 32'(ocupado), 32'd0);
    checkOutput("rst fim", 32'(fim), 32'd0);
    checkOutput("rst addr", 32'(endereco), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] directed three-move sequence");
    mem[0] = 4'b0001;
    mem[1] = 4'b0110;
    mem[2] = 4'b1011;
    runPlayback(2, 0, 1'b0);

    $display("[TB] single move, iniciar held in FIM");
    mem[0] = 4'b1000;
    runPlayback(0, 0, 1'b1);

    $display("[TB] random playbacks");
    repeat (4) begin
      fillMemory();
      runPlayback(int'($urandom_range(0, 15)), 0, 1'b0);
    end

    $display("[TB] full memory");
    fillMemory();
    runPlayback(15, 0, 1'b0);

    $display("[TB] iniciar and limite change mid-playback");
    fillMemory();
    runPlayback(2, 12, 1'b0);

    $display("[TB] abort during ACESO");
    fillMemory();
    limite  = 4'd2;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("abort pre leds", 32'(leds), 32'(modelLeds(mem[0])));
    parar = 1'b1;
    @(negedge clock);
    checkOutput("abort leds", 32'(leds), 32'd0);
    checkOutput("abort ocup", 32'(ocupado), 32'd0);
    checkOutput("abort addr", 32'(endereco), 32'd0);
    checkOutput("abort fim", 32'(fim), 32'd0);
    parar = 1'b0;
    @(negedge clock);
    checkOutput("abort idle", 32'(ocupado), 32'd0);
    runPlayback(2, 0, 1'b0);

    $display("[TB] reset during APAGADO");
    fillMemory();
    limite  = 4'd1;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("pre rst ocup", 32'(ocupado), 32'd1);
    reset   = 1'b1;
    iniciar = 1'b1;
    @(negedge clock);
    checkOutput("rst2 leds", 32'(leds), 32'd0);
    checkOutput("rst2 ocup", 32'(ocupado), 32'd0);
    checkOutput("rst2 addr", 32'(endereco), 32'd0);
    checkOutput("rst2 fim", 32'(fim), 32'd0);
    reset   = 1'b0;
    iniciar = 1'b0;
    @(negedge clock);
    checkOutput("rst2 idle", 32'(ocupado), 32'd0);
    runPlayback(1, 0, 1'b0);

    $display("[TB] encoder sweep");
    for (int w = 0; w < 16; w++) begin
      palavraSweep = 4'(w);
      #1;
      checkOutput($sformatf("enc w%0d", w), 32'(ledsSweep), 32'(modelLeds(4'(w))));
      checkOutput($sformatf("onehot w%0d", w), 32'($countones(ledsSweep[5:2])), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
